// File: rtl/alu_request_scheduler.sv
// Round-robin front end that shares one registered 16-bit ALU among NUM_REQ requesters,
// sequencing a single operation at a time and buffering the response behind valid/ready.
module alu_request_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ALU_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [3*NUM_REQ-1:0]    req_opcode,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  output logic [2:0]              alu_opcode,
  output logic [15:0]             alu_a,
  output logic [15:0]             alu_b,
  input  logic [15:0]             alu_result,
  input  logic                    alu_overflow,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [15:0]             resp_result,
  output logic                    resp_overflow,
  output logic                    resp_illegal,
  output logic                    busy,
  output logic [15:0]             op_count
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
  // the valid side holds its payload stable until then and may withdraw valid freely.

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t            state, state_n;
  logic [ID_W-1:0]   last, grant, hi_g, lo_g, cur_id;
  logic              hi_f, lo_f, any_req, exec_done;
  logic [2:0]        cur_op, sel_op;
  logic [15:0]       sel_a, sel_b;
  logic [CNT_W-1:0]  cnt;

  // Lowest valid index above last wins; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_g = '0;
    lo_g = '0;
    hi_f = 1'b0;
    lo_f = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_g = ID_W'(i);
        lo_f = 1'b1;
        if (ID_W'(i) > last) begin
          hi_g = ID_W'(i);
          hi_f = 1'b1;
        end
      end
    end
    grant   = hi_f ? hi_g : lo_g;
    any_req = lo_f;
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_op = req_opcode[3*i +: 3];
        sel_a  = req_a[16*i +: 16];
        sel_b  = req_b[16*i +: 16];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rst_n && (state == IDLE) && any_req && (grant == ID_W'(i));
    end
  end

  assign exec_done = (cnt == CNT_W'(ALU_LAT - 1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = EXEC;
      EXEC:    if (exec_done) state_n = CAPT;
      CAPT:    state_n = RESP;
      RESP:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode    <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      resp_valid    <= 1'b0;
      resp_id       <= '0;
      resp_result   <= '0;
      resp_overflow <= 1'b0;
      resp_illegal  <= 1'b0;
      op_count      <= '0;
      last          <= ID_W'(NUM_REQ - 1);
      cur_id        <= '0;
      cur_op        <= '0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            alu_opcode <= sel_op;
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            cur_id     <= grant;
            cur_op     <= sel_op;
            last       <= grant;
            cnt        <= '0;
          end
        end
        EXEC: cnt <= cnt + 1'b1;
        CAPT: begin
          // Overflow only means something for ADD/SUB; other opcodes mask it.
          resp_valid    <= 1'b1;
          resp_id       <= cur_id;
          resp_result   <= alu_result;
          resp_overflow <= alu_overflow & (cur_op[2:1] == 2'b00);
          resp_illegal  <= cur_op[2] & cur_op[1];
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            op_count   <= op_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_request_scheduler.sv
// Randomised bench for alu_request_scheduler: behavioural ALU, round-robin reference model
// and a response scoreboard, plus directed scenarios for the documented corner cases.
module tb_alu_request_scheduler;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int ALU_LAT = 1;
  localparam int EW      = ID_W + 18;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid, req_ready;
  logic [3*NUM_REQ-1:0]  req_opcode;
  logic [16*NUM_REQ-1:0] req_a, req_b;
  logic [2:0]            alu_opcode;
  logic [15:0]           alu_a, alu_b, alu_result;
  logic                  alu_overflow;
  logic                  resp_valid, resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [15:0]           resp_result;
  logic                  resp_overflow, resp_illegal, busy;
  logic [15:0]           op_count;

  logic [2:0]  p_op [NUM_REQ];
  logic [15:0] p_a  [NUM_REQ];
  logic [15:0] p_b  [NUM_REQ];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [EW-1:0] exp_q[$];
  int            grants_q[$];
  int            last_m, hs_cyc, w_m, hs_i;
  logic          outstanding, prev_rv, junk_ovf, refill_all, rand_mode;
  logic [15:0]   cnt_m;
  logic [NUM_REQ-1:0] hs_mask;
  logic [ID_W-1:0]    last_id;
  logic [15:0]        last_res;
  logic               last_ovf, last_ill;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign req_opcode[3*g +: 3] = p_op[g];
    assign req_a[16*g +: 16]    = p_a[g];
    assign req_b[16*g +: 16]    = p_b[g];
  end

  alu_request_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result),
    .resp_overflow(resp_overflow), .resp_illegal(resp_illegal),
    .busy(busy), .op_count(op_count)
  );

  function automatic logic [15:0] ref_res(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    r = ref_res(op, a, b);
    if (op == 3'd0) return (a[15] == b[15]) && (r[15] != a[15]);
    if (op == 3'd1) return (a[15] != b[15]) && (r[15] != a[15]);
    return 1'b0;
  endfunction

  // External ALU stand-in; non-arithmetic overflow is driven with junk to exercise masking.
  always @(posedge clk) begin
    alu_result   <= ref_res(alu_opcode, alu_a, alu_b);
    alu_overflow <= (alu_opcode > 3'd1) ? junk_ovf : ref_ovf(alu_opcode, alu_a, alu_b);
  end

  function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int j;
      j = (last + k) % NUM_REQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor / scoreboard: samples everything on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_ctl", 32'({alu_opcode, req_ready, busy}), 32'd0);
        check("rst_resp", 32'({resp_valid, resp_id, resp_overflow, resp_illegal}), 32'd0);
        check("rst_result", 32'(resp_result), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        exp_q.delete();
        last_m = NUM_REQ - 1; cnt_m = 16'd0; outstanding = 1'b0;
        prev_rv = 1'b0; hs_mask = '0;
      end else begin
        hs_mask = req_valid & req_ready;
        w_m = rr_pick(last_m, req_valid);
        if (!outstanding && w_m >= 0) check("grant", 32'(req_ready), 32'(NUM_REQ'(1) << w_m));
        else check("no_grant", 32'(req_ready), 32'd0);
        check("busy", 32'(busy), 32'(outstanding));
        check("op_count", 32'(op_count), 32'(cnt_m));
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            check("resp_unexpected", 32'd1, 32'd0);
          end else begin
            check("resp", 32'({resp_id, resp_result, resp_overflow, resp_illegal}), 32'(exp_q[0]));
            if (!prev_rv) check("latency", 32'(cyc - hs_cyc), 32'(ALU_LAT + 2));
            if (resp_ready) begin
              last_id = resp_id; last_res = resp_result;
              last_ovf = resp_overflow; last_ill = resp_illegal;
              void'(exp_q.pop_front());
              cnt_m = cnt_m + 16'd1;
              outstanding = 1'b0;
            end
          end
        end
        prev_rv = resp_valid;
        if (hs_mask != 0) begin
          hs_i = 0;
          for (int i = 0; i < NUM_REQ; i++) if (hs_mask[i]) hs_i = i;
          exp_q.push_back({ID_W'(hs_i), ref_res(p_op[hs_i], p_a[hs_i], p_b[hs_i]),
                           ref_ovf(p_op[hs_i], p_a[hs_i], p_b[hs_i]), p_op[hs_i][2] & p_op[hs_i][1]});
          grants_q.push_back(hs_i);
          last_m = hs_i; hs_cyc = cyc; outstanding = 1'b1;
        end
      end
    end
  end

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 3))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic set_req(input int i, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    p_op[i] = op; p_a[i] = a; p_b[i] = b; req_valid[i] = 1'b1;
  endtask

  task automatic new_req(input int i);
    set_req(i, 3'($urandom_range(0, 7)), pick16(), pick16());
  endtask

  task automatic tick();
    @(posedge clk); #1;
    req_valid = req_valid & ~hs_mask;
    if (refill_all) begin
      for (int i = 0; i < NUM_REQ; i++) if (!req_valid[i]) new_req(i);
    end else if (rand_mode) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) new_req(i);
        else if (req_valid[i] && $urandom_range(0, 39) == 0) req_valid[i] = 1'b0;
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      junk_ovf   = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((req_valid != 0 || outstanding) && n < budget) begin
      tick();
      n++;
    end
    check("done_in_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b1; req_valid = '0; resp_ready = 1'b1; junk_ovf = 1'b0;
    refill_all = 1'b0; rand_mode = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin p_op[i] = '0; p_a[i] = '0; p_b[i] = '0; end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Signed ADD overflow from requester 0.
    set_req(0, 3'b000, 16'h7FFF, 16'h0001);
    wait_done(20);
    check("t1_id", 32'(last_id), 32'd0);
    check("t1_result", 32'(last_res), 32'h8000);
    check("t1_ovf", 32'(last_ovf), 32'd1);

    // All four continuously requesting: strict rotation from requester 0.
    do_reset();
    grants_q.delete();
    refill_all = 1'b1;
    n = 0;
    while (cnt_m < 16'd8 && n < 200) begin tick(); n++; end
    refill_all = 1'b0;
    req_valid = '0;
    check("t2_op_count", 32'(op_count), 32'd8);
    check("t2_grants_n", 32'(grants_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < grants_q.size(); k++) check("t2_order", 32'(grants_q[k]), 32'(k % NUM_REQ));

    // AND with ALU overflow flag forced high: must be masked.
    junk_ovf = 1'b1;
    set_req(2, 3'b010, 16'hFFFF, 16'h00FF);
    wait_done(20);
    check("t3_id", 32'(last_id), 32'd2);
    check("t3_result", 32'(last_res), 32'h00FF);
    check("t3_ovf", 32'(last_ovf), 32'd0);

    // Illegal opcode.
    set_req(1, 3'b111, 16'h1234, 16'($urandom));
    wait_done(20);
    check("t4_result", 32'(last_res), 32'd0);
    check("t4_illegal", 32'(last_ill), 32'd1);
    check("t4_ovf", 32'(last_ovf), 32'd0);

    // Response backpressure with another requester pending.
    resp_ready = 1'b0;
    set_req(3, 3'b001, 16'h8000, 16'h0001);
    n = 0;
    while (!resp_valid && n < 20) begin tick(); n++; end
    check("t5_resp_seen", 32'(resp_valid), 32'd1);
    set_req(0, 3'b011, 16'h0F0F, 16'hF000);
    repeat (5) begin
      tick();
      check("t5_hold_valid", 32'(resp_valid), 32'd1);
      check("t5_no_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_next_grant", 32'(req_ready), 32'b0001);
    check("t5_result", 32'({last_id, last_res, last_ovf}), 32'({2'd3, 16'h7FFF, 1'b1}));
    wait_done(20);

    // Asynchronous reset in the middle of EXEC.
    set_req(0, 3'b000, 16'h1234, 16'h0001);
    tick();
    check("t6_in_exec", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_abort_ctl", 32'({busy, resp_valid, req_ready, alu_opcode}), 32'd0);
    check("t6_abort_alu", 32'({alu_a, alu_b}), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    grants_q.delete();
    set_req(1, 3'b100, 16'hAAAA, 16'h5555);
    set_req(0, 3'b101, 16'h00F0, 16'h0000);
    wait_done(30);
    check("t6_grants_n", 32'(grants_q.size()), 32'd2);
    if (grants_q.size() > 0) check("t6_first_grant", 32'(grants_q[0]), 32'd0);

    // Randomised traffic with withdrawals and backpressure.
    rand_mode = 1'b1;
    repeat (800) tick();
    rand_mode = 1'b0;
    req_valid = '0;
    resp_ready = 1'b1;
    wait_done(50);
    check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
